// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit single-cycle CPU front end.
// Loader state encodings, instruction width and default fill word.
package cpu_pkg;

    localparam int INS_W = 8;

    localparam logic [INS_W-1:0] DEF_FILL_INS = 8'h00;

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/btn_edge.sv
// Button conditioner: 2-flop synchronizer then rising-edge pulse.
// Ports: clk, rst_n (async low), btn (raw) -> pulse (1 cycle per press).
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic s1;
    logic s2;
    logic prev;
    logic warm;
    logic armed;

    // A button already held across reset must not count as a press:
    // pulses are enabled only after the synchronized input is seen low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            prev  <= 1'b0;
            warm  <= 1'b0;
            armed <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            prev  <= s2;
            warm  <= 1'b1;
            armed <= armed | (warm & ~s1);
        end
    end

    assign pulse = s2 & ~prev & armed;

endmodule

// File: rtl/instr_loader.sv
// Program RAM loaded from switches, served combinationally to the CPU.
// Ports: CLK, RESET(async low), SW, LOAD_BTN, RUN_BTN, PC -> Ins, RUN_EN, LEN, FULL, MODE.
module instr_loader
    import cpu_pkg::*;
#(
    parameter int               AW       = 4,
    parameter logic [INS_W-1:0] FILL_INS = DEF_FILL_INS
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [INS_W-1:0] SW,
    input  logic             LOAD_BTN,
    input  logic             RUN_BTN,
    input  logic [INS_W-1:0] PC,
    output logic [INS_W-1:0] Ins,
    output logic             RUN_EN,
    output logic [AW:0]      LEN,
    output logic             FULL,
    output logic [1:0]       MODE
);

    localparam int DEPTH = 2 ** AW;

    logic ld_p;
    logic run_p;

    state_t state;
    state_t state_nx;

    logic [INS_W-1:0] mem [DEPTH];

    logic             wr;
    logic [AW:0]      len_nx;
    logic [INS_W-1:0] len_ext;
    logic             in_range;

    btn_edge u_ld (
        .clk   (CLK),
        .rst_n (RESET),
        .btn   (LOAD_BTN),
        .pulse (ld_p)
    );

    btn_edge u_run (
        .clk   (CLK),
        .rst_n (RESET),
        .btn   (RUN_BTN),
        .pulse (run_p)
    );

    assign wr       = ld_p && (state == ST_LOAD) && !FULL;
    assign len_nx   = LEN + {{AW{1'b0}}, wr};
    assign len_ext  = {{(INS_W - AW - 1){1'b0}}, LEN};
    assign in_range = PC < len_ext;

    always_ff @(posedge CLK) begin
        if (wr) begin
            mem[LEN[AW-1:0]] <= SW;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= ST_LOAD;
            LEN   <= '0;
            FULL  <= 1'b0;
        end else begin
            state <= state_nx;
            LEN   <= len_nx;
            FULL  <= (len_nx == (AW + 1)'(DEPTH));
        end
    end

    // run_p takes priority over the end-of-program check in RUN.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_LOAD: begin
                if (run_p && (len_nx != '0)) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (run_p) begin
                    state_nx = ST_LOAD;
                end else if (!in_range) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                if (run_p) begin
                    state_nx = ST_LOAD;
                end
            end
            default: state_nx = ST_LOAD;
        endcase
    end

    assign RUN_EN = (state == ST_RUN);
    assign MODE   = state;
    assign Ins    = (RUN_EN && in_range) ? mem[PC[AW-1:0]] : FILL_INS;

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader.
// Presses buttons, sweeps PC and compares against hand-computed values.
module tb_instr_loader;

    logic       CLK;
    logic       RESET;
    logic [7:0] SW;
    logic       LOAD_BTN;
    logic       RUN_BTN;
    logic [7:0] PC;
    logic [7:0] Ins;
    logic       RUN_EN;
    logic [4:0] LEN;
    logic       FULL;
    logic [1:0] MODE;

    int nvec = 0;
    int nerr = 0;

    instr_loader #(.AW(4), .FILL_INS(8'h00)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .SW       (SW),
        .LOAD_BTN (LOAD_BTN),
        .RUN_BTN  (RUN_BTN),
        .PC       (PC),
        .Ins      (Ins),
        .RUN_EN   (RUN_EN),
        .LEN      (LEN),
        .FULL     (FULL),
        .MODE     (MODE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk8(input string nm, input logic [7:0] act,
                        input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    task automatic press(input bit ld, input bit run);
        @(negedge CLK);
        LOAD_BTN = ld;
        RUN_BTN  = run;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        LOAD_BTN = 1'b0;
        RUN_BTN  = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic load_word(input logic [7:0] w);
        SW = w;
        press(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        LOAD_BTN = 1'b1;
        RUN_BTN  = 1'b1;
        SW       = 8'h77;
        RESET    = 1'b0;
        #1;
        nvec++;
        if (MODE !== 2'b00) begin
            nerr++;
            $display("FAIL reset_mode: got %b want 00", MODE);
        end
        nvec++;
        if (LEN !== 5'd0) begin
            nerr++;
            $display("FAIL reset_len: got %0d want 0", LEN);
        end
        nvec++;
        if (RUN_EN !== 1'b0) begin
            nerr++;
            $display("FAIL reset_run_en: got %b want 0", RUN_EN);
        end
        chk8("reset_ins", Ins, 8'h00);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        repeat (6) @(negedge CLK);
        nvec++;
        if (LEN !== 5'd0 || MODE !== 2'b00) begin
            nerr++;
            $display("FAIL reset_held_btn: len %0d mode %b want 0 00",
                     LEN, MODE);
        end
        LOAD_BTN = 1'b0;
        RUN_BTN  = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_load_run();
        PC = 8'd0;
        load_word(8'h41);
        load_word(8'h52);
        load_word(8'h93);
        nvec++;
        if (LEN !== 5'd3) begin
            nerr++;
            $display("FAIL lr_len: got %0d want 3", LEN);
        end
        press(1'b0, 1'b1);
        nvec++;
        if (MODE !== 2'b01 || RUN_EN !== 1'b1) begin
            nerr++;
            $display("FAIL lr_run: mode %b run_en %b want 01 1",
                     MODE, RUN_EN);
        end
        PC = 8'd0; #1 chk8("lr_pc0", Ins, 8'h41);
        PC = 8'd1; #1 chk8("lr_pc1", Ins, 8'h52);
        PC = 8'd2; #1 chk8("lr_pc2", Ins, 8'h93);
        @(negedge CLK);
        PC = 8'd3;
        #1 chk8("lr_pc3_ins", Ins, 8'h00);
        nvec++;
        if (MODE !== 2'b01) begin
            nerr++;
            $display("FAIL lr_pre_done: mode %b want 01", MODE);
        end
        @(negedge CLK);
        nvec++;
        if (MODE !== 2'b10 || RUN_EN !== 1'b0) begin
            nerr++;
            $display("FAIL lr_done: mode %b run_en %b want 10 0",
                     MODE, RUN_EN);
        end
        PC = 8'd0;
        @(negedge CLK);
        nvec++;
        if (MODE !== 2'b10) begin
            nerr++;
            $display("FAIL lr_done_sticky: mode %b want 10", MODE);
        end
    endtask

    task automatic test_ignored();
        load_word(8'hEE);
        nvec++;
        if (LEN !== 5'd3) begin
            nerr++;
            $display("FAIL ig_ld_done: len %0d want 3", LEN);
        end
        press(1'b0, 1'b1);
        nvec++;
        if (MODE !== 2'b00) begin
            nerr++;
            $display("FAIL ig_run_done: mode %b want 00", MODE);
        end
        load_word(8'hC4);
        nvec++;
        if (LEN !== 5'd4) begin
            nerr++;
            $display("FAIL ig_append_len: len %0d want 4", LEN);
        end
        PC = 8'd0;
        press(1'b0, 1'b1);
        load_word(8'hDD);
        nvec++;
        if (LEN !== 5'd4 || MODE !== 2'b01) begin
            nerr++;
            $display("FAIL ig_ld_run: len %0d mode %b want 4 01",
                     LEN, MODE);
        end
        PC = 8'd0; #1 chk8("ig_keep0", Ins, 8'h41);
        PC = 8'd3; #1 chk8("ig_append3", Ins, 8'hC4);
        PC = 8'd0;
        press(1'b0, 1'b1);
        nvec++;
        if (MODE !== 2'b00) begin
            nerr++;
            $display("FAIL ig_run_back: mode %b want 00", MODE);
        end
        apply_reset();
        press(1'b0, 1'b1);
        nvec++;
        if (MODE !== 2'b00 || LEN !== 5'd0) begin
            nerr++;
            $display("FAIL ig_run_empty: mode %b len %0d want 00 0",
                     MODE, LEN);
        end
    endtask

    task automatic test_full();
        apply_reset();
        PC = 8'd0;
        for (int i = 0; i < 16; i++) begin
            load_word(8'h10 + 8'(i));
        end
        nvec++;
        if (FULL !== 1'b1 || LEN !== 5'd16) begin
            nerr++;
            $display("FAIL full_16: full %b len %0d want 1 16", FULL, LEN);
        end
        load_word(8'hFF);
        nvec++;
        if (LEN !== 5'd16 || FULL !== 1'b1) begin
            nerr++;
            $display("FAIL full_17: len %0d full %b want 16 1", LEN, FULL);
        end
        press(1'b0, 1'b1);
        PC = 8'd0;  #1 chk8("full_mem0", Ins, 8'h10);
        PC = 8'd15; #1 chk8("full_mem15", Ins, 8'h1F);
        PC = 8'd16; #1 chk8("full_pc16", Ins, 8'h00);
        @(negedge CLK);
        nvec++;
        if (MODE !== 2'b10) begin
            nerr++;
            $display("FAIL full_done: mode %b want 10", MODE);
        end
        PC = 8'd0;
    endtask

    task automatic test_simul();
        apply_reset();
        SW = 8'hA5;
        PC = 8'd0;
        press(1'b1, 1'b1);
        nvec++;
        if (LEN !== 5'd1 || MODE !== 2'b01 || RUN_EN !== 1'b1) begin
            nerr++;
            $display("FAIL simul: len %0d mode %b run_en %b want 1 01 1",
                     LEN, MODE, RUN_EN);
        end
        chk8("simul_ins", Ins, 8'hA5);
    endtask

    task automatic test_reset_mid_run();
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        nvec++;
        if (RUN_EN !== 1'b0 || LEN !== 5'd0 || MODE !== 2'b00) begin
            nerr++;
            $display("FAIL mid_reset: run_en %b len %0d mode %b want 0 0 00",
                     RUN_EN, LEN, MODE);
        end
        chk8("mid_reset_ins", Ins, 8'h00);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        RESET    = 1'b1;
        SW       = 8'h00;
        LOAD_BTN = 1'b0;
        RUN_BTN  = 1'b0;
        PC       = 8'h00;
        test_reset();
        test_load_run();
        test_ignored();
        test_full();
        test_simul();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
